// File: rtl/ndma_write_arb.sv
// Round-robin arbiter sharing one NanoDMA write manager among NUM_CH channels.
// Optional watchdog: define NDMA_WARB_TIMEOUT_EN to enable timeout + sticky err_o.
module ndma_write_arb #(
  parameter int NUM_CH         = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_CH-1:0]    ch_req_i,
  input  logic [NUM_CH*32-1:0] ch_addr_i,
  input  logic [NUM_CH*32-1:0] ch_wdata_i,
  output logic [NUM_CH-1:0]    ch_gnt_o,
  output logic [NUM_CH-1:0]    ch_done_o,
  output logic                 wr_req_o,
  output logic [31:0]          wr_addr_o,
  output logic [31:0]          wr_wdata_o,
  input  logic                 wr_busy_i,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;
  logic            r_wr_req;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;

  logic            w_any;
  logic [PW-1:0]   w_win;
  logic [PW-1:0]   w_j;
  logic [PW-1:0]   w_next_ptr;
  logic            w_tmo_hit;

  // First requester at or after the pointer, scanning upward with wrap.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_j   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_j = PW'((int'(r_ptr) + i) % NUM_CH);
      if (!w_any && ch_req_i[w_j]) begin
        w_any = 1'b1;
        w_win = w_j;
      end
    end
  end

  assign w_next_ptr = (w_win == PW'(NUM_CH - 1)) ? '0 : w_win + 1'b1;

  // Grant and done are same-cycle strobes; masked so reset forces them low.
  assign ch_gnt_o   = (r_state == IDLE && w_any && !rst_i) ? (NUM_CH'(1) << w_win) : '0;
  assign ch_done_o  = (r_state == WAIT_DONE && !wr_busy_i && !rst_i) ? (NUM_CH'(1) << r_owner) : '0;
  assign wr_req_o   = r_wr_req;
  assign wr_addr_o  = r_addr;
  assign wr_wdata_o = r_wdata;
  assign busy_o     = (r_state != IDLE);

`ifdef NDMA_WARB_TIMEOUT_EN
  logic [31:0] r_cnt;
  logic        r_err;

  assign w_tmo_hit = (r_cnt == 32'(TIMEOUT_CYCLES - 1)) &&
                     (r_state == WAIT_BUSY || (r_state == WAIT_DONE && wr_busy_i));
  assign err_o     = r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == ISSUE)
        r_cnt <= '0;
      else if (r_state == WAIT_BUSY || r_state == WAIT_DONE)
        r_cnt <= r_cnt + 32'd1;
      if (w_tmo_hit)
        r_err <= 1'b1;
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_tmo_hit    = 1'b0;
  assign err_o        = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_wr_req <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_wr_req <= 1'b0;
      case (r_state)
        IDLE: if (w_any) begin
          r_addr   <= ch_addr_i[{w_win, 5'b0} +: 32];
          r_wdata  <= ch_wdata_i[{w_win, 5'b0} +: 32];
          r_owner  <= w_win;
          r_ptr    <= w_next_ptr;
          r_wr_req <= 1'b1;
          r_state  <= ISSUE;
        end
        ISSUE: r_state <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (w_tmo_hit)      r_state <= IDLE;
          else if (wr_busy_i) r_state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // Completion outranks the watchdog when both land together.
          if (!wr_busy_i || w_tmo_hit) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
